pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_entry.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 182 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers.
//   stage_state_e : occupancy state of a stage (EMPTY / ONE / TWO)
//   OCC_W         : width of the occupancy count
//   NOP_INSTR     : instruction word used to build the bubble payload
//   state_occ()   : maps a stage state to its held-entry count
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int OCC_W = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Number of entries held in a given state; unknown encodings report zero.
  function automatic logic [OCC_W-1:0] state_occ(input stage_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry
// One payload register of a pipeline stage, with load and clear-to-bubble.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (register returns to BUBBLE)
//   clear  in   synchronous clear to BUBBLE, dominates load
//   load   in   capture d on the next rising edge
//   d      in   DATA_W payload to capture
//   q      out  DATA_W held payload
// -----------------------------------------------------------------------------
module pipe_entry #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_r;

  // Payload register: clear wins over load so a squash never keeps stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= BUBBLE;
    end else if (clear) begin
      data_r <= BUBBLE;
    end else if (load) begin
      data_r <= d;
    end else begin
      data_r <= data_r;
    end
  end

  assign q = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register (e.g. IR + NPC between two stages) with
// flush, one cycle of latency and full throughput.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> main + skid entry (states EMPTY/ONE/TWO),
//                                    in_ready is a register, so no combinational
//                                    path from out_ready to in_ready.
//                       undefined -> single entry (states EMPTY/ONE),
//                                    in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk        in   clock, all state changes on rising edge
//   rst_n      in   asynchronous active-low reset, discards all entries
//   in_valid   in   upstream offers in_data
//   in_data    in   DATA_W upstream payload
//   in_ready   out  stage accepts in_data this cycle
//   out_valid  out  out_data holds a valid entry
//   out_data   out  DATA_W payload, BUBBLE whenever out_valid=0
//   out_ready  in   downstream consumes; 0 stalls the stage
//   flush      in   synchronous squash of all held entries, beats handshakes
//   occupancy  out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'({((DATA_W + 31) / 32){NOP_INSTR}})
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy
);

  stage_state_e      state_r;
  stage_state_e      state_nxt_s;
  logic              accept_s;
  logic              emit_s;
  logic              main_load_s;
  logic              clear_s;
  logic [DATA_W-1:0] main_d_s;
  logic [DATA_W-1:0] main_q_s;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_r;
  logic              skid_load_s;
  logic              main_from_skid_s;
  logic [DATA_W-1:0] skid_q_s;
`endif

  // Handshake qualifiers; flush cancels any acceptance in the same cycle.
  assign accept_s = in_valid & in_ready & ~flush;
  assign emit_s   = out_valid & out_ready;

  // Next-state and entry-control decode.
  always_comb begin
    state_nxt_s = state_r;
    main_load_s = 1'b0;
    clear_s     = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
`endif
    if (flush) begin
      // An entry emitted in the flush cycle is already consumed downstream;
      // the stage only has to forget everything it holds.
      state_nxt_s = EMPTY;
      clear_s     = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_load_s = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && !emit_s) begin
`ifdef PIPE_STAGE_SKID_EN
            skid_load_s = 1'b1;
            state_nxt_s = TWO;
`else
            // Cannot happen: while full, in_ready requires out_ready.
            state_nxt_s = ONE;
`endif
          end else if (emit_s && !accept_s) begin
            state_nxt_s = EMPTY;
          end else if (accept_s && emit_s) begin
            main_load_s = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = ONE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          // in_ready is low in TWO, so only the drain of main matters here.
          if (emit_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            state_nxt_s      = ONE;
          end else begin
            state_nxt_s = TWO;
          end
        end
`endif
        default: begin
          // Illegal encoding: recover to a clean empty stage.
          state_nxt_s = EMPTY;
          clear_s     = 1'b1;
        end
      endcase
    end
  end

  // Stage occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign main_d_s = main_from_skid_s ? skid_q_s : in_data;

  // Registered ready: looks only at where the stage is going, not at out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= (state_nxt_s != TWO);
    end
  end

  assign in_ready = in_ready_r;

  pipe_entry #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .load  (skid_load_s),
    .d     (in_data),
    .q     (skid_q_s)
  );
`else
  assign main_d_s = in_data;
  assign in_ready = ~out_valid | out_ready;
`endif

  pipe_entry #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .load  (main_load_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  // main keeps its last payload after draining, so gate it with out_valid.
  assign out_valid = (state_r != EMPTY);
  assign out_data  = out_valid ? main_q_s : BUBBLE;
  assign occupancy = state_occ(state_r);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue of held entries (capacity 1
// or 2 depending on PIPE_STAGE_SKID_EN) predicts every output on each falling
// edge; directed sequences add literal expectations, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DATA_W = 64;
  localparam logic [63:0] BUB    = 64'h0;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic [63:0] in_data   = 64'h0;
  logic        out_ready = 1'b0;
  logic        flush     = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  bit          m_acc;
  bit          m_emi;

  pipe_stage_reg #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready the stage must show: a two-deep stage is ready unless full; a
  // one-deep stage is ready when empty or when its entry leaves this cycle.
  function automatic bit model_in_ready();
    if (CAP == 2) return (q.size() < 2);
    else          return (q.size() == 0) || out_ready;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list of held entries in arrival order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_acc = in_valid && model_in_ready() && !flush;
      m_emi = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (m_emi) void'(q.pop_front());
        if (m_acc) q.push_back(in_data);
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("out_data",  out_data, (q.size() != 0) ? q[0] : BUB);
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready",  64'(in_ready), 64'(model_in_ready()));
  end

  initial begin
    // Reset state, observed without any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  out_data, BUB);
    check("rst_in_ready",  64'(in_ready), 64'h1);
    check("rst_occupancy", 64'(occupancy), 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Streaming 1..4, first accept on the first edge after release.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 64'(i);
      step();
      check("stream_data",  out_data, 64'(i));
      check("stream_valid", 64'(out_valid), 64'h1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 64'(out_valid), 64'h0);

`ifdef PIPE_STAGE_SKID_EN
    // Stall with two entries, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    check("stall_occ1", 64'(occupancy), 64'h1);
    in_data = 64'hB;
    step();
    check("stall_occ2",   64'(occupancy), 64'h2);
    check("stall_ready0", 64'(in_ready), 64'h0);
    check("stall_head",   out_data, 64'hA);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("stall_second", out_data, 64'hB);
    step();
    check("stall_empty", 64'(out_valid), 64'h0);
`else
    // Single entry stalled: ready drops and occupancy stays at one.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hD;
    step();
    check("cfg_occ1",   64'(occupancy), 64'h1);
    check("cfg_ready0", 64'(in_ready), 64'h0);
    in_data = 64'hE;
    step();
    check("cfg_occ_hold",  64'(occupancy), 64'h1);
    check("cfg_data_hold", out_data, 64'hD);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("cfg_empty", 64'(out_valid), 64'h0);
`endif

    // Flush a full stage while 0xC is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      in_data = 64'hA1 + 64'(i);
      step();
    end
    check("flush_pre_occ", 64'(occupancy), 64'(CAP));
    flush   = 1'b1;
    in_data = 64'hC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_data",  out_data, BUB);
    check("flush_occ",   64'(occupancy), 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_c", 64'(out_valid), 64'h0);
    end

    // Reset mid-stream with traffic still offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'h0);
    check("midrst_data",  out_data, BUB);
    check("midrst_ready", 64'(in_ready), 64'h1);
    check("midrst_occ",   64'(occupancy), 64'h0);
    flush = 1'b1;
    step();
    check("midrst_hold", 64'(out_valid), 64'h0);
    flush = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    in_data = 64'h77;
    step();
    check("post_rst_accept", out_data, 64'h77);
    check("post_rst_occ",    64'(occupancy), 64'h1);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_data   = {$urandom, $urandom};
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("final_empty", 64'(out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
